mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the CPU data port, in parallel with `dram`. It decodes a small address window, buffers CPU store bytes in an 8-entry FIFO and serialises them as 8N1 frames on `tx`. Status is readable by the CPU, so firmware can poll before writing. The board muxes `read_data` from this block whenever `sel` is high.

---
 rtl/riscv_mmio_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/mmio_uart_tx.sv | 151 +++++++++++++++
 tb/tb_mmio_uart_tx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit layout and the TX state encoding.
package riscv_mmio_pkg;

    localparam logic [2:0] TXDATA_OFFSET = 3'h0;
    localparam logic [2:0] STATUS_OFFSET = 3'h4;

    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_EMPTY   = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_COUNT   = 8;
    localparam int unsigned ST_COUNT_W = 5;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with power-of-two depth; head is combinationally valid on dout.
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        count   = count_q;
        dout    = mem_q[rd_ptr_q];
        push_ok = push & ~full;
        pop_ok  = pop & ~empty;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a FIFO, STATUS reports
// busy/full/empty/overflow/count; frames are sent back-to-back while data is queued.
module mmio_uart_tx
    import riscv_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        dram_read,
    input  logic        dram_write,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        sel,
    output logic        tx
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    logic [7:0]                  fifo_dout;
    logic                        fifo_full, fifo_empty, fifo_pop, push_req;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        is_status, ovf_clr;
    logic [31:0]                 status;
    logic                        unused_bits;

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        ovf_q, ovf_d;
    logic        wrap;

    always_comb begin
        sel         = (address[31:3] == BASE_ADDR[31:3]);
        is_status   = (address[2] == STATUS_OFFSET[2]);
        push_req    = sel & dram_write & ~is_status;
        ovf_clr     = sel & dram_write & is_status & write_data[ST_OVF];
        unused_bits = ^{address[1:0], write_data[31:8]};
    end

    always_comb begin
        status                          = '0;
        status[ST_BUSY]                 = (state_q != TX_IDLE);
        status[ST_FULL]                 = fifo_full;
        status[ST_EMPTY]                = fifo_empty;
        status[ST_OVF]                  = ovf_q;
        status[ST_COUNT +: ST_COUNT_W]  = 5'(fifo_count);
        read_data = (sel & dram_read & is_status) ? status : 32'h0;
        tx        = tx_q;
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (write_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Set has priority over a same-cycle clear so an overflow is never lost.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr)               ovf_d = 1'b0;
        if (push_req && fifo_full) ovf_d = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        wrap     = (cnt_q == LAST_CNT);
        if (state_q != TX_IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + 16'd1;
        end
        case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    idx_d    = '0;
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                if (wrap) begin
                    idx_d   = '0;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (wrap) begin
                    if (idx_q == 3'd7) state_d = TX_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            TX_STOP: begin
                if (wrap) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        idx_d    = '0;
                        state_d  = TX_START;
                    end else begin
                        state_d  = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
        // Line level follows the next state so tx changes on the same edge as the FSM.
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shift_d[idx_d];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random bus traffic, checked each
// cycle against a frame-timeline model of the serial line and the STATUS register.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int          C     = 16;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = '0;
    logic        dram_read = 1'b0;
    logic        dram_write = 1'b0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        sel;
    logic        tx;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .dram_read  (dram_read),
        .dram_write (dram_write),
        .write_data (write_data),
        .read_data  (read_data),
        .sel        (sel),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    // Reference model: queued bytes, and the position inside the current frame.
    logic [7:0] m_q[$];
    logic [7:0] m_cur;
    logic       m_active;
    int         m_elapsed;
    logic       m_ovf;
    logic       m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int bp;
        if (!m_active) return 1'b1;
        bp = m_elapsed / C;
        if (bp == 0) return 1'b0;
        if (bp <= 8) return m_cur[bp-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = m_active;
        s[1]     = (m_q.size() == DEPTH);
        s[2]     = (m_q.size() == 0);
        s[3]     = m_ovf;
        s[12:8]  = 5'(m_q.size());
        return s;
    endfunction

    task automatic model_edge(input logic [31:0] a, input logic rd, input logic wr,
                              input logic [31:0] wd, input logic rst);
        logic in_win, push, clr, pre_full;
        int   pre_size;
        if (rst) begin
            m_q.delete();
            m_active  = 1'b0;
            m_elapsed = 0;
            m_ovf     = 1'b0;
            m_valid   = 1'b1;
            return;
        end
        in_win   = (a[31:3] == BASE[31:3]);
        push     = in_win && wr && !a[2];
        clr      = in_win && wr && a[2] && wd[3];
        pre_size = m_q.size();
        pre_full = (pre_size == DEPTH);
        if (!m_active) begin
            if (pre_size > 0) begin
                m_cur     = m_q.pop_front();
                m_active  = 1'b1;
                m_elapsed = 0;
            end
        end else if (m_elapsed == 10*C - 1) begin
            if (pre_size > 0) begin
                m_cur     = m_q.pop_front();
                m_elapsed = 0;
            end else begin
                m_active  = 1'b0;
            end
        end else begin
            m_elapsed++;
        end
        if (clr) m_ovf = 1'b0;
        if (push) begin
            if (pre_full) m_ovf = 1'b1;
            else          m_q.push_back(wd[7:0]);
        end
        if (rd) begin end
    endtask

    // One bus cycle: drive inputs, check outputs mid-cycle, then advance the model on the edge.
    task automatic step(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, input logic rst);
        logic [31:0] exp_rd;
        logic        exp_sel;
        address    = a;
        dram_read  = rd;
        dram_write = wr;
        write_data = wd;
        reset      = rst;
        @(negedge clk);
        if (m_valid) begin
            exp_sel = (a[31:3] == BASE[31:3]);
            exp_rd  = (exp_sel && rd && a[2]) ? exp_status() : 32'h0;
            check("tx", {31'b0, tx}, {31'b0, exp_tx()});
            check("sel", {31'b0, sel}, {31'b0, exp_sel});
            check("read_data", read_data, exp_rd);
        end
        @(posedge clk);
        model_edge(a, rd, wr, wd, rst);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(BASE + 32'd4, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd);
        step(a, 1'b1, 1'b1, wd, 1'b0);
    endtask

    initial begin
        logic found;
        logic [31:0] a;
        int kind;

        #1;
        step(BASE, 1'b0, 1'b0, '0, 1'b1);
        step(BASE, 1'b0, 1'b0, '0, 1'b1);
        idle(50);
        check("status_after_reset", read_data, 32'h0000_0004);

        store(BASE, 32'h0000_00A5);
        idle(170);

        store(BASE, 32'h0000_00C3);
        idle(5);
        for (int i = 1; i <= 9; i++) store(BASE, 32'(i));
        idle(20);
        store(BASE + 32'd4, 32'h0000_0008);
        idle(9 * 10 * C + 20);

        step(BASE,          1'b1, 1'b0, '0, 1'b0);
        step(BASE + 32'd8,  1'b1, 1'b0, '0, 1'b0);
        step(32'h1234_5678, 1'b1, 1'b0, '0, 1'b0);
        step(BASE + 32'd8,  1'b1, 1'b1, 32'h55, 1'b0);
        idle(5);

        for (int i = 0; i < 4; i++) store(BASE, 32'($urandom_range(0, 255)));
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (m_active && (m_elapsed / C) == 5) found = 1'b1;
            else idle(1);
        end
        check("reach_bit4", {31'b0, found}, 32'h1);
        step(BASE, 1'b1, 1'b1, 32'h77, 1'b1);
        idle(1);
        check("status_after_midframe_reset", read_data, 32'h0000_0004);
        idle(300);

        for (int i = 0; i < 5000; i++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0:       a = BASE;
                1:       a = BASE + 32'd4;
                2:       a = BASE + 32'd8;
                default: a = $urandom();
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            step(a,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < ((kind == 0) ? 8 : 5)),
                 $urandom(),
                 ($urandom_range(0, 999) < 2));
        end
        idle(10 * C * (DEPTH + 1) + 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
